// File: rtl/column_drop_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : column_drop_if
// Brief    : Drop request / column result bundle for column_drop_unit.
//            master = requester (drives drop/clear), slave = the unit.
// Revision : 1.0 - initial release
// ============================================================================
interface column_drop_if #(
    parameter int ROWS = 6
) ();
    logic            drop_req;
    logic [2:0]      drop_col;
    logic            player;
    logic            clear;
    logic            drop_ready;
    logic            check_valid;
    logic [ROWS-1:0] sel_player_register;
    logic [ROWS-1:0] sel_onoff_register;
    logic            sel_player;
    logic [2:0]      placed_row;
    logic            rejected;
    logic            board_full;

    modport master (
        output drop_req, drop_col, player, clear,
        input  drop_ready, check_valid, sel_player_register, sel_onoff_register,
               sel_player, placed_row, rejected, board_full
    );

    modport slave (
        input  drop_req, drop_col, player, clear,
        output drop_ready, check_valid, sel_player_register, sel_onoff_register,
               sel_player, placed_row, rejected, board_full
    );
endinterface
`default_nettype wire

// File: rtl/column_drop_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : column_drop_unit
// Brief    : Gravity drop engine for a COLS x ROWS board. Scans the target
//            column bottom-up one row per cycle, places the piece in the
//            lowest free cell and pulses check_valid, or pulses rejected for
//            a full or out-of-range column.
// Revision : 1.0 - initial release
// ============================================================================
module column_drop_unit #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    column_drop_if.slave      bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SCAN   = 3'd1;
    localparam logic [2:0] c_PLACE  = 3'd2;
    localparam logic [2:0] c_CHECK  = 3'd3;
    localparam logic [2:0] c_REJECT = 3'd4;

    localparam logic [5:0] c_CELLS   = 6'(COLS * ROWS);
    localparam logic [2:0] c_TOP_ROW = 3'(ROWS - 1);

    logic [2:0]      r_state;
    logic [2:0]      r_col_q;
    logic [2:0]      r_scan_row;
    logic            r_sel_player;
    logic [2:0]      r_placed_row;
    logic [5:0]      r_count;
    logic [ROWS-1:0] r_onoff [COLS];
    logic [ROWS-1:0] r_owner [COLS];

    logic            w_col_ok;
    logic            w_req_col_ok;
    logic [ROWS-1:0] w_sel_onoff;
    logic [ROWS-1:0] w_sel_owner;
    logic            w_cell_busy;

    // An out-of-range latched column has no storage behind it; it reads as empty.
    assign w_col_ok     = int'(r_col_q) < COLS;
    assign w_req_col_ok = int'(bus.drop_col) < COLS;

    // Present the selected column straight from storage so CHECK sees the new piece.
    always_comb begin
        w_sel_onoff = '0;
        w_sel_owner = '0;
        if (w_col_ok) begin
            w_sel_onoff = r_onoff[r_col_q];
            w_sel_owner = r_owner[r_col_q];
        end
    end

    assign w_cell_busy = w_sel_onoff[r_scan_row];

    // Control FSM, drop bookkeeping and piece counter; clear overrides everything.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_col_q      <= '0;
            r_scan_row   <= '0;
            r_sel_player <= 1'b0;
            r_placed_row <= '0;
            r_count      <= '0;
        end else if (bus.clear) begin
            r_state      <= c_IDLE;
            r_scan_row   <= '0;
            r_placed_row <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.drop_req) begin
                        r_col_q      <= bus.drop_col;
                        r_sel_player <= bus.player;
                        r_scan_row   <= '0;
                        r_state      <= w_req_col_ok ? c_SCAN : c_REJECT;
                    end
                end
                c_SCAN: begin
                    if (!w_cell_busy) begin
                        r_state <= c_PLACE;
                    end else if (r_scan_row == c_TOP_ROW) begin
                        r_state <= c_REJECT;
                    end else begin
                        r_scan_row <= r_scan_row + 3'd1;
                    end
                end
                c_PLACE: begin
                    r_placed_row <= r_scan_row;
                    if (r_count != c_CELLS) begin
                        r_count <= r_count + 6'd1;
                    end
                    r_state <= c_CHECK;
                end
                c_CHECK:  r_state <= c_IDLE;
                c_REJECT: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    // Board storage: one occupancy and one owner bit per cell, written only in PLACE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < COLS; c++) begin
                r_onoff[c] <= '0;
                r_owner[c] <= '0;
            end
        end else if (bus.clear) begin
            for (int c = 0; c < COLS; c++) begin
                r_onoff[c] <= '0;
                r_owner[c] <= '0;
            end
        end else if (r_state == c_PLACE && w_col_ok) begin
            r_onoff[r_col_q][r_scan_row] <= 1'b1;
            r_owner[r_col_q][r_scan_row] <= r_sel_player;
        end
    end

    assign bus.drop_ready          = (r_state == c_IDLE);
    assign bus.check_valid         = (r_state == c_CHECK);
    assign bus.rejected            = (r_state == c_REJECT);
    assign bus.sel_onoff_register  = w_sel_onoff;
    assign bus.sel_player_register = w_sel_owner;
    assign bus.sel_player          = r_sel_player;
    assign bus.placed_row          = r_placed_row;
    assign bus.board_full          = (r_count == c_CELLS);
endmodule
`default_nettype wire

// File: tb/tb_column_drop_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_column_drop_unit
// Brief    : Scoreboard bench for column_drop_unit. Each issued drop pushes
//            its expected outcome; a monitor pops on every check_valid or
//            rejected pulse and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_drop_unit;
    logic clock;
    logic resetn;
    int   cyc;
    int   n_total;
    int   n_pass;

    column_drop_if #(.ROWS(6)) bus ();

    column_drop_unit #(.ROWS(6), .COLS(7)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        bit         is_check;
        bit         chk_regs;
        int         cyc;
        logic [5:0] onoff;
        logic [5:0] owner;
        logic [2:0] row;
        logic       spl;
        logic       full;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [5:0] m_onoff [7];
    logic [5:0] m_owner [7];
    int         m_count;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 7; c++) begin
            m_onoff[c] = '0;
            m_owner[c] = '0;
        end
        m_count = 0;
    endtask

    // Reference behaviour of one accepted drop; call at the negedge before the accept edge.
    task automatic expect_drop(input int col, input bit pl);
        exp_t e;
        int   r;
        e.is_check = 1'b0;
        e.chk_regs = 1'b0;
        e.onoff    = '0;
        e.owner    = '0;
        e.row      = '0;
        e.spl      = pl;
        if (col >= 7) begin
            e.cyc = cyc + 1;
        end else begin
            r = -1;
            for (int i = 0; i < 6; i++)
                if (r < 0 && !m_onoff[col][i]) r = i;
            if (r < 0) begin
                e.chk_regs = 1'b1;
                e.cyc      = cyc + 7;
            end else begin
                m_onoff[col][r] = 1'b1;
                m_owner[col][r] = pl;
                m_count++;
                e.is_check = 1'b1;
                e.chk_regs = 1'b1;
                e.cyc      = cyc + r + 3;
                e.row      = r[2:0];
            end
            e.onoff = m_onoff[col];
            e.owner = m_owner[col];
        end
        e.full = (m_count == 42);
        q.push_back(e);
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            if (bus.drop_ready) seen = 1'b1;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL ready_timeout: drop_ready stayed 0 for 50 cycles (cycle %0d)", cyc);
        end
    endtask

    // Issue one drop; hold keeps drop_req high for extra edges while the unit is busy.
    task automatic drop(input int col, input bit pl, input int hold);
        wait_ready();
        expect_drop(col, pl);
        bus.drop_req = 1'b1;
        bus.drop_col = 3'(col);
        bus.player   = pl;
        @(posedge clock);
        repeat (hold) @(posedge clock);
        #1 bus.drop_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_drop_ready"},  bus.drop_ready, 1);
        chk({tag, "_check_valid"}, bus.check_valid, 0);
        chk({tag, "_rejected"},    bus.rejected, 0);
        chk({tag, "_board_full"},  bus.board_full, 0);
        chk({tag, "_sel_onoff"},   bus.sel_onoff_register, 0);
        chk({tag, "_sel_player_reg"}, bus.sel_player_register, 0);
        chk({tag, "_placed_row"},  bus.placed_row, 0);
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetn && (bus.check_valid || bus.rejected)) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: check_valid=%0b rejected=%0b, nothing expected (cycle %0d)",
                         bus.check_valid, bus.rejected, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_kind", bus.check_valid, mon_e.is_check);
                chk("pulse_exclusive", bus.check_valid & bus.rejected, 0);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("board_full", bus.board_full, mon_e.full);
                if (mon_e.chk_regs) begin
                    chk("sel_onoff_register", bus.sel_onoff_register, mon_e.onoff);
                    chk("sel_player_register", bus.sel_player_register, mon_e.owner);
                end
                if (mon_e.is_check) begin
                    chk("placed_row", bus.placed_row, mon_e.row);
                    chk("sel_player", bus.sel_player, mon_e.spl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total      = 0;
        n_pass       = 0;
        cyc          = 0;
        resetn       = 1'b0;
        bus.drop_req = 1'b0;
        bus.drop_col = '0;
        bus.player   = 1'b0;
        bus.clear    = 1'b0;
        model_clear();

        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        resetn = 1'b1;

        // Single piece; drop_req held through the busy cycles must not queue a second drop.
        drop(3, 1'b1, 2);

        // Stack four player-0 pieces in column 0.
        for (int i = 0; i < 4; i++) drop(0, 1'b0, 0);

        // Fill column 5, then overflow it.
        for (int i = 0; i < 6; i++) drop(5, i[0], 0);
        drop(5, 1'b1, 0);

        // Out-of-range column.
        drop(7, 1'b0, 0);

        // Reset while the column 2 drop is in SCAN; nothing may land.
        wait_ready();
        bus.drop_req = 1'b1;
        bus.drop_col = 3'd2;
        bus.player   = 1'b1;
        @(posedge clock);
        #1 bus.drop_req = 1'b0;
        resetn = 1'b0;
        #1 chk_reset_outputs("midscan_reset");
        model_clear();
        repeat (2) @(negedge clock);
        chk_reset_outputs("held_reset");

        // Release with a request already pending: accepted on the first edge.
        expect_drop(2, 1'b1);
        bus.drop_req = 1'b1;
        bus.drop_col = 3'd2;
        bus.player   = 1'b1;
        resetn       = 1'b1;
        @(posedge clock);
        #1 bus.drop_req = 1'b0;

        // Fill the rest of the board.
        for (int c = 0; c < 7; c++)
            for (int i = 0; i < 6; i++)
                if (!(c == 2 && i == 0)) drop(c, ((c + i) % 2) == 1, 0);
        wait_ready();
        chk("board_full_after_42", bus.board_full, 1);

        // Any column on a full board is refused.
        drop(4, 1'b0, 0);

        // Clear together with a drop request: clear wins, drop discarded.
        wait_ready();
        bus.clear    = 1'b1;
        bus.drop_req = 1'b1;
        bus.drop_col = 3'd0;
        bus.player   = 1'b1;
        @(posedge clock);
        #1;
        bus.clear    = 1'b0;
        bus.drop_req = 1'b0;
        model_clear();
        @(negedge clock);
        chk("clear_board_full", bus.board_full, 0);
        chk("clear_drop_ready", bus.drop_ready, 1);
        chk("clear_sel_onoff", bus.sel_onoff_register, 0);
        chk("clear_sel_player_reg", bus.sel_player_register, 0);
        chk("clear_placed_row", bus.placed_row, 0);

        // Board usable again after clear.
        drop(6, 1'b0, 0);
        drop(6, 1'b1, 0);

        wait_ready();
        repeat (4) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/column_drop_unit.md
COLUMN_DROP_UNIT -- requirements
Module: column_drop_unit

Interface
REQ-001 Parameter: ROWS, 6, rows per column; row 0 is the bottom row and maps to bit 0 of each column register.
REQ-002 Parameter: COLS, 7, columns on the board; column indices run 0..COLS-1.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 drop_req  input  1  request to drop a piece; qualified by drop_ready.
REQ-006 drop_col  input  3  target column, sampled when the request is accepted.
REQ-007 player  input  1  owner of the piece (1 = player 1, 0 = player 0), sampled with drop_col.
REQ-008 clear  input  1  synchronous board clear.
REQ-009 drop_ready  output  1  high only in IDLE.
REQ-010 check_valid  output  1  one-cycle pulse; the column outputs hold the updated column.
REQ-011 sel_player_register  output  6  player bits of the selected column (1 = player 1 piece).
REQ-012 sel_onoff_register  output  6  occupancy bits of the selected column (1 = occupied).
REQ-013 sel_player  output  1  registered owner of the last accepted drop.
REQ-014 placed_row  output  3  row written by the last successful drop.
REQ-015 rejected  output  1  one-cycle pulse when a drop is refused.
REQ-016 board_full  output  1  high when all COLS*ROWS cells are occupied.

Function
REQ-017 Storage SHALL be two arrays: onoff[COLS][ROWS] and owner[COLS][ROWS]; owner bits SHALL be meaningful only where onoff=1, and owner SHALL be written 0 on every clear.
REQ-018 FSM states: IDLE, SCAN, PLACE, CHECK, REJECT.
REQ-019 IDLE: when drop_req=1, the block SHALL latch drop_col and player into col_q and sel_player, and SHALL set scan_row=0.
REQ-020 IDLE: drop_col>=COLS SHALL go to REJECT; drop_col<COLS SHALL go to SCAN; drop_req=0 SHALL stay in IDLE.
REQ-021 SCAN SHALL test one row per cycle.
REQ-022 SCAN: if onoff[col_q][scan_row]=0, go to PLACE.
REQ-023 SCAN: else if scan_row=ROWS-1, go to REJECT (column full).
REQ-024 SCAN: else increment scan_row and stay in SCAN.
REQ-025 PLACE SHALL set onoff[col_q][scan_row]=1, owner[col_q][scan_row]=sel_player, and placed_row=scan_row, then go to CHECK.
REQ-026 CHECK SHALL assert check_valid for exactly one cycle, then go to IDLE.
REQ-027 REJECT SHALL assert rejected for exactly one cycle, SHALL leave the board unchanged, then go to IDLE.
REQ-028 sel_player_register and sel_onoff_register SHALL always show column col_q combinationally from storage, so that in CHECK they include the new piece.
REQ-029 Latency from accept (IDLE edge) to check_valid for a piece landing at row r SHALL be r+3 cycles: r+1 SCAN, 1 PLACE, 1 CHECK.
REQ-030 A full column SHALL give rejected ROWS+1 cycles after accept.
REQ-031 An invalid column SHALL give rejected 1 cycle after accept.
REQ-032 drop_req outside IDLE SHALL be ignored and not queued.
REQ-033 The downstream win checker SHALL consume the column outputs and sel_player only while check_valid=1.
REQ-034 A 6-bit piece counter SHALL increment in PLACE, saturating at COLS*ROWS.
REQ-035 board_full SHALL equal (counter == COLS*ROWS).
REQ-036 clear=1 SHALL take priority over all FSM activity in any state.
REQ-037 On the next edge after clear=1: all onoff/owner bits 0, counter 0, state IDLE, placed_row 0, no check_valid or rejected pulse.
REQ-038 clear and drop_req asserted in the same cycle: clear SHALL win and the drop SHALL be discarded.

Reset
REQ-039 resetn=0 SHALL immediately force state=IDLE, all storage 0, counter 0, col_q 0, scan_row 0, sel_player 0, and placed_row 0.
REQ-040 During reset, outputs SHALL be: drop_ready=1, check_valid=0, rejected=0, board_full=0, sel_*_register=6'b000000.
REQ-041 Reset asserted mid-SCAN or mid-PLACE SHALL abort the drop with no partial write surviving.
REQ-042 After resetn rises, the first drop SHALL be accepted on the first clock edge with drop_req=1.

Verification
REQ-043 Empty board; drop col 3, player 1 -> check_valid 3 cycles after accept, placed_row=0, sel_onoff_register=000001, sel_player_register=000001.
REQ-044 Four player-0 drops into col 0 -> fourth check_valid has sel_onoff_register=001111, sel_player_register=000000, placed_row=3, latency 6 cycles.
REQ-045 Col 5 filled with 6 pieces, 7th drop -> rejected pulse 7 cycles after accept, storage unchanged, board_full=0.
REQ-046 drop_col=7 -> rejected 1 cycle after accept, no check_valid, counter unchanged.
REQ-047 42 valid drops -> board_full=1; then clear=1 for one cycle -> board_full=0, all registers 0, drop_ready=1.
REQ-048 resetn pulled low in SCAN during a col 2 drop -> no check_valid; after release col 2 reads 000000.
